pixel_plotter: RTL and testbench
================================

PIXEL_PLOTTER -- requirements
Module: pixel_plotter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  pixel offered by the line-drawing source.
REQ-004 SHALL have port in_ready  output  1  plotter can accept a pixel this cycle.
REQ-005 SHALL have port in_x  input  10  pixel column, unsigned.
REQ-006 SHALL have port in_y  input  9  pixel row, unsigned.
REQ-007 SHALL have port in_color  input  1  pixel value (1 = draw, 0 = erase).
REQ-008 SHALL have port wr_en  output  1  framebuffer write request.
REQ-009 SHALL have port wr_addr  output  19  framebuffer address, y*640 + x.
REQ-010 SHALL have port wr_data  output  1  framebuffer write data.
REQ-011 SHALL have port mem_stall  input  1  framebuffer cannot take a write this cycle.
REQ-012 SHALL have port drop_count  output  16  number of clipped pixels since reset.
REQ-013 SHALL have port idle  output  1  FIFO empty and no pixel in the pipeline.

Function
REQ-014 SHALL accept a pixel at every rising edge where in_valid=1 and in_ready=1, pushing {x,y,color} into a 4-entry FIFO.
REQ-015 SHALL drive in_ready = (FIFO occupancy < 4) from registered state only; a pop in the same cycle does not raise in_ready when the FIFO is full.
REQ-016 SHALL use a two-stage pipeline. S1 pops the FIFO head, performs the clip test and computes y*640 as (y<<9)+(y<<7). S2 adds x and registers wr_addr, wr_data and wr_en.
REQ-017 SHALL have latency: pixel accepted at edge N with an empty pipeline and mem_stall=0 gives wr_en=1 between edges N+2 and N+3, and is committed at edge N+3.
REQ-018 SHALL sustain one write per cycle while the FIFO is non-empty and mem_stall=0.
REQ-019 SHALL treat a write as committed at any edge where wr_en=1 and mem_stall=0.
REQ-020 SHALL, while wr_en=1 and mem_stall=1, hold wr_addr and wr_data stable and freeze S1, S2 and FIFO pops; FIFO pushes continue while space remains.
REQ-021 SHALL clip in S1: a pixel with x >= 640 or y >= 480 is not forwarded (S2 receives a bubble) and drop_count increments by 1, saturating at 16'hFFFF.
REQ-022 SHALL hold wr_en=0 whenever S2 holds no valid pixel; wr_addr and wr_data are don't-care then.
REQ-023 SHALL compute wr_addr as exactly 19 bits; with in-range inputs the maximum is 307199 and no overflow occurs.
REQ-024 SHALL drive idle=1 only when the FIFO is empty, S1 and S2 are invalid, and in_valid is ignored.
REQ-025 SHALL let simultaneous push and pop at occupancy 1..3 leave the occupancy unchanged and preserve FIFO order.

Reset
REQ-026 SHALL, on an edge with reset=1, empty the FIFO, invalidate S1 and S2, and set drop_count=0.
REQ-027 SHALL drive these outputs during and after reset: wr_en=0, wr_addr=0, wr_data=0, in_ready=1 (from the first cycle after reset), idle=1.
REQ-028 SHALL, on reset mid-operation, discard all queued and in-flight pixels with no further write; a pixel offered during the reset cycle is not accepted.

Configuration
REQ-029 SHALL, with macro PIXEL_PLOTTER_DEDUP_EN defined, drop in S1 any in-range pixel whose {address, color} equals the last committed write. Such a drop does not touch drop_count. The last-write record is invalid after reset.
REQ-030 SHALL, without PIXEL_PLOTTER_DEDUP_EN, forward every in-range pixel, duplicates included.

Verification
REQ-031 SHALL cover: single pixel (x=5, y=2, color=1) at edge N -> wr_en=1 with wr_addr=1285, wr_data=1, committed at edge N+3.
REQ-032 SHALL cover: 8 back-to-back pixels (0,0)..(7,0) with no stall -> 8 consecutive wr_en cycles, addresses 0..7 in order, in_ready never low.
REQ-033 SHALL cover: mem_stall=1 for 10 cycles while streaming -> wr_addr held stable, in_ready falls after 4 more accepts, no pixel lost or duplicated after release.
REQ-034 SHALL cover: pixels (640,0), (0,480), (639,479) -> only wr_addr=307199 written, drop_count=2.
REQ-035 SHALL cover: reset asserted with 3 pixels queued -> no wr_en afterwards, idle=1, drop_count=0, in_ready=1.
REQ-036 SHALL cover: with DEDUP_EN, pixel (3,3,1) sent twice -> one write (addr 1923); without DEDUP_EN -> two writes.

Source files
------------

// File: rtl/pixel_plotter_if.sv
// Pixel-input handshake and framebuffer write port
// shared by the plotter and its source/sink.
interface pixel_plotter_if;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_x;
    logic [8:0]  in_y;
    logic        in_color;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic        wr_data;
    logic        mem_stall;

    modport master (
        output in_valid, in_x, in_y, in_color, mem_stall,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_x, in_y, in_color, mem_stall,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pixel_plotter.sv
// Pixel plotter: 4-deep FIFO, clip stage, address stage.
// Optional PIXEL_PLOTTER_DEDUP_EN drops repeats of the last write.
module pixel_plotter (
    input  logic           clk,
    input  logic           reset,
    pixel_plotter_if.slave pix,
    output logic [15:0]    drop_count,
    output logic           idle
);
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       c;
    } pixel_t;

    pixel_t      fifo_q [4];
    logic [1:0]  wptr_q, rptr_q;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] drop_q, drop_d;

    logic        s1_v_q;
    logic [9:0]  s1_x_q;
    logic [18:0] s1_ym_q;
    logic        s1_c_q;
    logic        s2_v_q;
    logic [18:0] s2_addr_q;
    logic        s2_c_q;

    logic        stall, push, pop;
    logic        clip, dup, fwd;
    pixel_t      head;
    logic [18:0] head_y, head_ym;

    assign stall   = s2_v_q & pix.mem_stall;
    assign push    = pix.in_valid & ~cnt_q[2];
    assign pop     = ~stall & (cnt_q != 3'd0);
    assign head    = fifo_q[rptr_q];
    assign head_y  = {10'd0, head.y};
    assign head_ym = (head_y << 9) + (head_y << 7);
    assign clip    = (head.x >= 10'd640)
                   | (head.y >= 9'd480);

`ifdef PIXEL_PLOTTER_DEDUP_EN
    logic        last_v_q;
    logic [18:0] last_addr_q;
    logic        last_c_q;
    logic [18:0] head_addr;

    assign head_addr = head_ym + {9'd0, head.x};
    assign dup = last_v_q
               & (head_addr == last_addr_q)
               & (head.c == last_c_q);

    // Record tracks committed writes only.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_v_q    <= 1'b0;
            last_addr_q <= '0;
            last_c_q    <= 1'b0;
        end else if (s2_v_q & ~pix.mem_stall) begin
            last_v_q    <= 1'b1;
            last_addr_q <= s2_addr_q;
            last_c_q    <= s2_c_q;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign fwd = pop & ~clip & ~dup;

    always_comb begin
        cnt_d = cnt_q;
        if (push & ~pop)
            cnt_d = cnt_q + 3'd1;
        else if (pop & ~push)
            cnt_d = cnt_q - 3'd1;
        drop_d = drop_q;
        if (pop & clip & (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= {pix.in_x, pix.in_y,
                                   pix.in_color};
                wptr_q <= wptr_q + 2'd1;
            end
            if (pop)
                rptr_q <= rptr_q + 2'd1;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    // Data regs load only with real pixels so wr_addr
    // never picks up uninitialised FIFO contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s1_x_q    <= '0;
            s1_ym_q   <= '0;
            s1_c_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_addr_q <= '0;
            s2_c_q    <= 1'b0;
        end else if (~stall) begin
            s1_v_q <= fwd;
            if (fwd) begin
                s1_x_q  <= head.x;
                s1_ym_q <= head_ym;
                s1_c_q  <= head.c;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_addr_q <= s1_ym_q + {9'd0, s1_x_q};
                s2_c_q    <= s1_c_q;
            end
        end
    end

    assign pix.in_ready = ~cnt_q[2];
    assign pix.wr_en    = s2_v_q;
    assign pix.wr_addr  = s2_addr_q;
    assign pix.wr_data  = s2_c_q;
    assign drop_count   = drop_q;
    assign idle         = (cnt_q == 3'd0)
                        & ~s1_v_q & ~s2_v_q;
endmodule

// File: tb/tb_pixel_plotter.sv
// Self-checking bench for pixel_plotter: vector table,
// write scoreboard, stall / reset / dedup sequences.
module tb_pixel_plotter;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] drop_count;
    logic        idle;

    pixel_plotter_if pix ();

    pixel_plotter dut (
        .clk        (clk),
        .reset      (reset),
        .pix        (pix),
        .drop_count (drop_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        c;
        logic        ok;
        logic [18:0] addr;
    } vec_t;

    typedef struct packed {
        logic [18:0] addr;
        logic        d;
    } exp_t;

    exp_t sbq [$];
    exp_t e;
    vec_t tbl [14];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int commits   = 0;
    int last_edge = 0;
    int prev_edge = -10;
    int run       = 0;
    int max_run   = 0;
    bit ready_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && !pix.in_ready)
            ready_low = 1;
        if (!reset && pix.wr_en && !pix.mem_stall) begin
            commits++;
            last_edge = cyc + 1;
            if (last_edge == prev_edge + 1)
                run++;
            else
                run = 1;
            if (run > max_run)
                max_run = run;
            prev_edge = last_edge;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%0d data=%0d expected=none",
                         pix.wr_addr, pix.wr_data);
            end else begin
                e = sbq.pop_front();
                if (pix.wr_addr !== e.addr
                    || pix.wr_data !== e.d) begin
                    errors++;
                    $display("FAIL write_order got addr=%0d data=%0d expected addr=%0d data=%0d",
                             pix.wr_addr, pix.wr_data,
                             e.addr, e.d);
                end
            end
        end
    end

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d",
                     name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [18:0] a,
                            input logic d);
        sbq.push_back({a, d});
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        pix.in_valid  = 1'b0;
        pix.mem_stall = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sbq.delete();
        prev_edge = -10;
        run       = 0;
        max_run   = 0;
    endtask

    task automatic send(input logic [9:0] x,
                        input logic [8:0] y,
                        input logic c,
                        input logic ok,
                        input logic [18:0] a,
                        output int acc);
        logic rdy;
        acc = -1;
        pix.in_x     = x;
        pix.in_y     = y;
        pix.in_color = c;
        pix.in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            rdy = pix.in_ready;
            tick();
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        pix.in_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=none expected=accept");
        end else if (ok) begin
            exp_push(a, c);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            if (idle && sbq.size() == 0)
                break;
            tick();
        end
        check("drain_idle", {31'd0, idle}, 1);
        check("drain_pending", sbq.size(), 0);
    endtask

    task automatic wait_wr_en();
        for (int t = 0; t < 20; t++) begin
            if (pix.wr_en)
                break;
            tick();
        end
        check("wait_wr_en", {31'd0, pix.wr_en}, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int          acc, c0, nwr, ndrop, acc_n, k;
        logic        rdy, stable;
        logic [18:0] held;

        for (int i = 0; i < 8; i++)
            tbl[i] = '{10'(i), 9'd0, 1'b1, 1'b1, 19'(i)};
        tbl[8]  = '{10'd640,  9'd0,   1'b1, 1'b0, 19'd0};
        tbl[9]  = '{10'd0,    9'd480, 1'b1, 1'b0, 19'd0};
        tbl[10] = '{10'd639,  9'd479, 1'b1, 1'b1, 19'd307199};
        tbl[11] = '{10'd1023, 9'd511, 1'b0, 1'b0, 19'd0};
        tbl[12] = '{10'd639,  9'd0,   1'b0, 1'b1, 19'd639};
        tbl[13] = '{10'd0,    9'd1,   1'b1, 1'b1, 19'd640};

        pix.in_valid  = 1'b0;
        pix.in_x      = '0;
        pix.in_y      = '0;
        pix.in_color  = 1'b0;
        pix.mem_stall = 1'b0;
        reset         = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_wr_en", {31'd0, pix.wr_en}, 0);
        check("rst_wr_addr", {13'd0, pix.wr_addr}, 0);
        check("rst_wr_data", {31'd0, pix.wr_data}, 0);
        check("rst_in_ready", {31'd0, pix.in_ready}, 1);
        check("rst_idle", {31'd0, idle}, 1);
        check("rst_drop", {16'd0, drop_count}, 0);

        send(10'd5, 9'd2, 1'b1, 1'b1, 19'd1285, acc);
        drain();
        check("latency_edge", last_edge, acc + 3);
        check("latency_writes", commits, 1);

        do_reset();
        ready_low = 0;
        c0    = commits;
        nwr   = 0;
        ndrop = 0;
        for (int i = 0; i < 14; i++) begin
            send(tbl[i].x, tbl[i].y, tbl[i].c,
                 tbl[i].ok, tbl[i].addr, acc);
            if (tbl[i].ok)
                nwr++;
            else
                ndrop++;
        end
        drain();
        check("table_drop", {16'd0, drop_count}, ndrop);
        check("table_writes", commits - c0, nwr);
        check("table_ready_low", {31'd0, ready_low}, 0);
        check("table_burst_run", max_run, 8);

        do_reset();
        c0 = commits;
        send(10'd20, 9'd3, 1'b1, 1'b1, 19'd1940, acc);
        wait_wr_en();
        held          = pix.wr_addr;
        pix.mem_stall = 1'b1;
        k      = 0;
        acc_n  = 0;
        stable = 1'b1;
        pix.in_x     = 10'd100;
        pix.in_y     = 9'd5;
        pix.in_color = 1'b1;
        pix.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rdy = pix.in_ready;
            tick();
            if (pix.wr_en !== 1'b1 || pix.wr_addr !== held)
                stable = 1'b0;
            if (rdy) begin
                exp_push(19'(3300 + k), 1'b1);
                acc_n++;
                k++;
                pix.in_x = 10'(100 + k);
            end
        end
        check("stall_hold", {31'd0, stable}, 1);
        check("stall_accepts", acc_n, 4);
        check("stall_ready", {31'd0, pix.in_ready}, 0);
        pix.in_valid  = 1'b0;
        pix.mem_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(10'(100 + k), 9'd5, 1'b1, 1'b1,
                 19'(3300 + k), acc);
            k++;
        end
        drain();
        check("stall_writes", commits - c0, 8);

        do_reset();
        send(10'd700, 9'd0, 1'b0, 1'b0, 19'd0, acc);
        send(10'd30, 9'd4, 1'b1, 1'b1, 19'd2590, acc);
        wait_wr_en();
        pix.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++)
            send(10'(31 + i), 9'd4, 1'b1, 1'b1,
                 19'(2591 + i), acc);
        check("pre_rst_drop", {16'd0, drop_count}, 1);
        check("pre_rst_idle", {31'd0, idle}, 0);
        pix.in_x     = 10'd9;
        pix.in_y     = 9'd9;
        pix.in_valid = 1'b1;
        reset        = 1'b1;
        tick();
        reset         = 1'b0;
        pix.in_valid  = 1'b0;
        pix.mem_stall = 1'b0;
        sbq.delete();
        c0 = commits;
        check("mid_rst_wr_en", {31'd0, pix.wr_en}, 0);
        check("mid_rst_idle", {31'd0, idle}, 1);
        check("mid_rst_drop", {16'd0, drop_count}, 0);
        check("mid_rst_ready", {31'd0, pix.in_ready}, 1);
        for (int i = 0; i < 15; i++)
            tick();
        check("mid_rst_writes", commits - c0, 0);
        check("mid_rst_idle_late", {31'd0, idle}, 1);

        do_reset();
        c0 = commits;
        send(10'd3, 9'd3, 1'b1, 1'b1, 19'd1923, acc);
        drain();
`ifdef PIXEL_PLOTTER_DEDUP_EN
        send(10'd3, 9'd3, 1'b1, 1'b0, 19'd1923, acc);
        drain();
        check("dedup_writes", commits - c0, 1);
`else
        send(10'd3, 9'd3, 1'b1, 1'b1, 19'd1923, acc);
        drain();
        check("dup_writes", commits - c0, 2);
`endif
        check("dup_drop", {16'd0, drop_count}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
